// File: rtl/csma_pkg.sv
// Shared definitions for the CSMA/CD transmit serializer.
//   tx_state_t      : serializer FSM states
//   FRAME_W_DEFAULT : default frame width (matches the framer output)
//   PREAMBLE        : optional per-attempt preamble byte, sent MSB-first
//   LFSR_TAPS       : Galois tap mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
//   lfsr_step()     : one LFSR advance
package csma_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SENSE   = 2'd1,
    TX      = 2'd2,
    BACKOFF = 2'd3
  } tx_state_t;

  localparam int          FRAME_W_DEFAULT = 256;
  localparam int          PREAMBLE_W      = 8;
  localparam logic [7:0]  PREAMBLE        = 8'hD5;
  localparam logic [15:0] LFSR_TAPS       = 16'hB400;

  // Right-shift Galois step: the bit falling out of the LSB folds back in
  // through the tap mask.
  function automatic logic [15:0] lfsr_step(input logic [15:0] state);
    return state[0] ? ((state >> 1) ^ LFSR_TAPS) : (state >> 1);
  endfunction

endpackage

// File: rtl/csma_tx_serializer_if.sv
// Handshake and line bundle between framer / medium and the serializer.
//   start          : 1-cycle request to send framed_message
//   framed_message : frame from the framer, sampled on an accepted start
//   channel_busy   : carrier sense (1 = medium occupied)
//   collision      : collision detect, meaningful only while tx_en=1
//   tx_data/tx_en  : serial bit and line-drive enable
//   busy/done/fail : serializer status and per-frame completion pulses
//   retry_cnt      : collisions seen for the current frame
// Modports: master = framer/medium side, slave = serializer.
interface csma_tx_serializer_if #(
  parameter int FRAME_W = csma_pkg::FRAME_W_DEFAULT
);

  logic               start;
  logic [FRAME_W-1:0] framed_message;
  logic               channel_busy;
  logic               collision;
  logic               tx_data;
  logic               tx_en;
  logic               busy;
  logic               done;
  logic               fail;
  logic [3:0]         retry_cnt;

  modport master (
    output start, framed_message, channel_busy, collision,
    input  tx_data, tx_en, busy, done, fail, retry_cnt
  );

  modport slave (
    input  start, framed_message, channel_busy, collision,
    output tx_data, tx_en, busy, done, fail, retry_cnt
  );

endinterface

// File: rtl/csma_backoff_lfsr.sv
// Random backoff timer for the CSMA/CD serializer.
// A free-running 16-bit Galois LFSR supplies the randomness; on load the low
// k bits of the LFSR become the slot count, and the timer then counts that
// many slots of SLOT_CYCLES clocks each.
// Ports:
//   clk     : clock, rising edge
//   reset   : asynchronous, active-low reset (LFSR <= LFSR_SEED, timer cleared)
//   load    : strobe on BACKOFF entry; samples the LFSR and arms the timer
//   k       : backoff exponent, already capped by the caller
//   expired : 1 once the armed wait has fully elapsed (also 1 when zero slots)
module csma_backoff_lfsr
  import csma_pkg::*;
#(
  parameter int          SLOT_CYCLES = 32,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] k,
  output logic       expired
);

  localparam int CYC_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  logic [15:0]      lfsr_reg;
  logic [15:0]      slot_mask;
  logic [15:0]      slot_cnt_reg, slot_cnt_next;
  logic [CYC_W-1:0] cyc_cnt_reg, cyc_cnt_next;

  // Thermometer mask selecting lfsr[k-1:0].
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_slot_mask
      assign slot_mask[gi] = (k > 4'(gi));
    end
  endgenerate

  // Two-level countdown: cyc_cnt walks through one slot, slot_cnt counts slots.
  // The wait therefore lasts exactly slots*SLOT_CYCLES clocks after the load.
  always_comb begin
    slot_cnt_next = slot_cnt_reg;
    cyc_cnt_next  = cyc_cnt_reg;
    if (load) begin
      slot_cnt_next = lfsr_reg & slot_mask;
      cyc_cnt_next  = CYC_W'(SLOT_CYCLES - 1);
    end else if (slot_cnt_reg != 16'd0) begin
      if (cyc_cnt_reg == '0) begin
        slot_cnt_next = slot_cnt_reg - 16'd1;
        cyc_cnt_next  = CYC_W'(SLOT_CYCLES - 1);
      end else begin
        cyc_cnt_next  = cyc_cnt_reg - CYC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_reg     <= LFSR_SEED;
      slot_cnt_reg <= 16'd0;
      cyc_cnt_reg  <= '0;
    end else begin
      lfsr_reg     <= lfsr_step(lfsr_reg);
      slot_cnt_reg <= slot_cnt_next;
      cyc_cnt_reg  <= cyc_cnt_next;
    end
  end

  assign expired = (slot_cnt_reg == 16'd0);

endmodule

// File: rtl/csma_tx_serializer.sv
// CSMA/CD transmit serializer: takes one framed message from the framer and
// shifts it onto the shared medium MSB-first, one bit per clock, after an
// inter-frame gap of idle carrier. A collision aborts the attempt and, until
// MAX_RETRY collisions have been seen, schedules a binary-exponential random
// backoff followed by a full retransmission.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset (all outputs and state cleared)
//   bus   : csma_tx_serializer_if.slave (start/framed_message/channel_busy/
//           collision in; tx_data/tx_en/busy/done/fail/retry_cnt out, all registered)
// Build option:
//   CSMA_TX_PREAMBLE_EN : when defined, every attempt is preceded by the 8-bit
//                         preamble 8'hD5 (MSB-first); a collision during the
//                         preamble is handled like any other collision.
module csma_tx_serializer
  import csma_pkg::*;
#(
  parameter int          FRAME_W         = FRAME_W_DEFAULT,
  parameter int          IFS_CYCLES      = 16,
  parameter int          SLOT_CYCLES     = 32,
  parameter int          MAX_RETRY       = 8,
  parameter int          BACKOFF_EXP_MAX = 6,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input logic                 clk,
  input logic                 reset,
  csma_tx_serializer_if.slave bus
);

`ifdef CSMA_TX_PREAMBLE_EN
  localparam int PRE_W = PREAMBLE_W;
`else
  localparam int PRE_W = 0;
`endif
  localparam int TX_LEN = FRAME_W + PRE_W;
  localparam int BIT_W  = $clog2(TX_LEN + 1);
  localparam int FIDX_W = $clog2(FRAME_W);
  localparam int IDLE_W = $clog2(IFS_CYCLES + 1);

  tx_state_t          state_reg, state_next;
  logic [FRAME_W-1:0] frame_reg, frame_next;
  logic [BIT_W-1:0]   bit_idx_reg, bit_idx_next;
  logic [IDLE_W-1:0]  idle_cnt_reg, idle_cnt_next;
  logic [3:0]         retry_cnt_reg, retry_cnt_next;
  logic               tx_data_reg, tx_data_next;
  logic               tx_en_reg, tx_en_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               fail_reg, fail_next;

  logic               backoff_load;
  logic [3:0]         backoff_k;
  logic               backoff_expired;
  logic [3:0]         retry_inc;
  logic [FIDX_W-1:0]  frame_pos;
  logic               cur_bit;
`ifdef CSMA_TX_PREAMBLE_EN
  logic [2:0]         pre_pos;
`endif

  csma_backoff_lfsr #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .LFSR_SEED   (LFSR_SEED)
  ) u_backoff (
    .clk     (clk),
    .reset   (reset),
    .load    (backoff_load),
    .k       (backoff_k),
    .expired (backoff_expired)
  );

  // Bit currently due on the line. With a preamble, bit_idx 0..7 index the
  // preamble and the frame occupies the remaining positions, so the frame bit
  // for any bit_idx is simply frame_reg[TX_LEN-1-bit_idx].
  always_comb begin
    frame_pos = FIDX_W'(TX_LEN - 1 - int'(bit_idx_reg));
`ifdef CSMA_TX_PREAMBLE_EN
    pre_pos   = 3'(PRE_W - 1 - int'(bit_idx_reg));
    cur_bit   = (int'(bit_idx_reg) < PRE_W) ? PREAMBLE[pre_pos] : frame_reg[frame_pos];
`else
    cur_bit   = frame_reg[frame_pos];
`endif
  end

  assign retry_inc = retry_cnt_reg + 4'd1;
  assign backoff_k = (retry_inc > 4'(BACKOFF_EXP_MAX)) ? 4'(BACKOFF_EXP_MAX) : retry_inc;

  always_comb begin
    state_next     = state_reg;
    frame_next     = frame_reg;
    bit_idx_next   = bit_idx_reg;
    idle_cnt_next  = idle_cnt_reg;
    retry_cnt_next = retry_cnt_reg;
    tx_data_next   = 1'b0;
    tx_en_next     = 1'b0;
    done_next      = 1'b0;
    fail_next      = 1'b0;
    backoff_load   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (bus.start) begin
          frame_next     = bus.framed_message;
          retry_cnt_next = 4'd0;
          idle_cnt_next  = '0;
          state_next     = SENSE;
        end
      end

      SENSE: begin
        if (bus.channel_busy) begin
          idle_cnt_next = '0;
        end else if (idle_cnt_reg == IDLE_W'(IFS_CYCLES - 1)) begin
          idle_cnt_next = '0;
          bit_idx_next  = '0;
          state_next    = TX;
        end else begin
          idle_cnt_next = idle_cnt_reg + IDLE_W'(1);
        end
      end

      TX: begin
        // Collision is only meaningful while we are actually driving, and it
        // takes priority over completing the last bit.
        if (tx_en_reg && bus.collision) begin
          retry_cnt_next = retry_inc;
          if (retry_inc == 4'(MAX_RETRY)) begin
            fail_next  = 1'b1;
            state_next = IDLE;
          end else begin
            backoff_load = 1'b1;
            state_next   = BACKOFF;
          end
        end else if (bit_idx_reg == BIT_W'(TX_LEN)) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end else begin
          tx_en_next   = 1'b1;
          tx_data_next = cur_bit;
          bit_idx_next = bit_idx_reg + BIT_W'(1);
        end
      end

      BACKOFF: begin
        if (backoff_expired) begin
          idle_cnt_next = '0;
          state_next    = SENSE;
        end
      end

      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      frame_reg     <= '0;
      bit_idx_reg   <= '0;
      idle_cnt_reg  <= '0;
      retry_cnt_reg <= 4'd0;
      tx_data_reg   <= 1'b0;
      tx_en_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      fail_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      frame_reg     <= frame_next;
      bit_idx_reg   <= bit_idx_next;
      idle_cnt_reg  <= idle_cnt_next;
      retry_cnt_reg <= retry_cnt_next;
      tx_data_reg   <= tx_data_next;
      tx_en_reg     <= tx_en_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      fail_reg      <= fail_next;
    end
  end

  assign bus.tx_data   = tx_data_reg;
  assign bus.tx_en     = tx_en_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.fail      = fail_reg;
  assign bus.retry_cnt = retry_cnt_reg;

endmodule

// File: tb/tb_csma_tx_serializer.sv
// Self-checking bench for csma_tx_serializer. Edge numbering: edge 0 is the
// clock edge that samples the start pulse; outputs are observed 1 time unit
// after each edge. Honours CSMA_TX_PREAMBLE_EN when the design is built with it.
module tb_csma_tx_serializer;
  import csma_pkg::*;

  localparam int FW     = 256;
  localparam int IFS    = 16;
  localparam int SLOT   = 32;
  localparam int MAXR   = 8;
  localparam int EXPMAX = 6;
`ifdef CSMA_TX_PREAMBLE_EN
  localparam int PRE_N = 8;
`else
  localparam int PRE_N = 0;
`endif
  localparam int LEN = FW + PRE_N;

  logic clk = 1'b0;
  logic reset = 1'b0;

  csma_tx_serializer_if #(.FRAME_W(FW)) bus();

  csma_tx_serializer #(
    .FRAME_W(FW), .IFS_CYCLES(IFS), .SLOT_CYCLES(SLOT), .MAX_RETRY(MAXR),
    .BACKOFF_EXP_MAX(EXPMAX), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor results of the most recent run_frame call.
  int            rise_q[$];
  int            fall_q[$];
  int            nbits_q[$];
  int            done_cnt, fail_cnt, done_t, fail_t, timed_out;
  logic [3:0]    retry_at_end;
  logic [LEN-1:0] first_bits, last_bits;
  bit            busy_plan [0:1023];

  // Expected line content for one complete attempt.
  function automatic logic [LEN-1:0] exp_stream(input logic [FW-1:0] f);
`ifdef CSMA_TX_PREAMBLE_EN
    logic [7:0] pre;
    pre = 8'b1101_0101;
    return {pre, f};
`else
    return f;
`endif
  endfunction

  // First start edge s>=0 such that edges s+1..s+IFS all see an idle channel;
  // tx_en then rises on edge s+IFS+1.
  function automatic int exp_first_rise();
    for (int s = 0; s < 1000; s++) begin
      bit ok;
      ok = 1'b1;
      for (int j = 1; j <= IFS; j++) if (busy_plan[s + j]) ok = 1'b0;
      if (ok) return s + IFS + 1;
    end
    return -1;
  endfunction

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int i = 0; i < FW / 32; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  task automatic clear_plan();
    for (int i = 0; i < 1024; i++) busy_plan[i] = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one start and observes the line until done/fail (+3 cycles) or the
  // budget expires. Collides at bit position coll_pos of attempts 1..coll_n;
  // optionally re-pulses start with alt at edge restart_t.
  task automatic run_frame(input logic [FW-1:0] frame, input int coll_pos, input int coll_n,
                           input int restart_t, input logic [FW-1:0] alt, input int budget);
    int t, attempt, bitpos, tail;
    logic prev_en;
    logic [LEN-1:0] cur;
    rise_q.delete(); fall_q.delete(); nbits_q.delete();
    done_cnt = 0; fail_cnt = 0; done_t = -1; fail_t = -1; timed_out = 0;
    retry_at_end = 4'hF; first_bits = '0; last_bits = '0;
    attempt = 0; bitpos = 0; tail = -1; prev_en = 1'b0; cur = '0;
    bus.framed_message = frame;
    bus.collision      = 1'b0;
    bus.channel_busy   = busy_plan[0];
    bus.start          = 1'b1;
    tick();
    bus.start = 1'b0;
    t = 0;
    forever begin
      if (bus.tx_en && !prev_en) begin
        rise_q.push_back(t); attempt++; bitpos = 0; cur = '0;
      end
      if (!bus.tx_en && prev_en) begin
        fall_q.push_back(t); nbits_q.push_back(bitpos);
        if (fall_q.size() == 1) first_bits = cur;
        last_bits = cur;
      end
      bus.collision = 1'b0;
      if (bus.tx_en) begin
        cur = {cur[LEN-2:0], bus.tx_data};
        if (attempt <= coll_n && bitpos == coll_pos) bus.collision = 1'b1;
        bitpos++;
      end
      if (bus.done) begin done_cnt++; done_t = t; retry_at_end = bus.retry_cnt; end
      if (bus.fail) begin fail_cnt++; fail_t = t; retry_at_end = bus.retry_cnt; end
      prev_en = bus.tx_en;
      bus.start = (t + 1 == restart_t);
      if (t + 1 == restart_t) bus.framed_message = alt;
      bus.channel_busy = (t + 1 < 1024) ? busy_plan[t + 1] : 1'b0;
      if (tail < 0 && (done_cnt + fail_cnt) > 0) tail = 3;
      if (tail == 0) break;
      if (tail > 0) tail--;
      if (t >= budget) begin timed_out = 1; break; end
      tick();
      t++;
    end
    bus.collision = 1'b0; bus.start = 1'b0; bus.channel_busy = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.framed_message = '0; bus.channel_busy = 1'b0; bus.collision = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    n_cmp++; if (bus.tx_en !== 1'b0) begin n_bad++; $display("FAIL reset_tx_en: got %b want 0", bus.tx_en); end
    n_cmp++; if (bus.tx_data !== 1'b0) begin n_bad++; $display("FAIL reset_tx_data: got %b want 0", bus.tx_data); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if ({bus.done, bus.fail} !== 2'b00) begin n_bad++; $display("FAIL reset_done_fail: got %b want 00", {bus.done, bus.fail}); end
    n_cmp++; if (bus.retry_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_retry_cnt: got %0d want 0", bus.retry_cnt); end
    #2 reset = 1'b1;
    tick();
    $display("reset: outputs checked, reset released");
  endtask

  task automatic test_idle_inputs();
    int bad;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      bus.channel_busy = 1'($urandom_range(0, 1));
      bus.collision    = 1'($urandom_range(0, 1));
      tick();
      if (bus.busy !== 1'b0 || bus.tx_en !== 1'b0 || bus.retry_cnt !== 4'd0) bad++;
    end
    bus.channel_busy = 1'b0; bus.collision = 1'b0;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL idle_inputs: %0d cycles left idle, want 0", bad); end
    $display("idle_inputs: 20 cycles of random busy/collision while idle");
  endtask

  task automatic test_idle_frame(input logic [FW-1:0] f, input string tag);
    logic [LEN-1:0] e;
    e = exp_stream(f);
    clear_plan();
    run_frame(f, -1, 0, -1, '0, 2000);
    n_cmp++; if (timed_out != 0) begin n_bad++; $display("FAIL %s_timeout: got timeout want completion", tag); end
    n_cmp++; if (rise_q.size() != 1 || rise_q[0] != IFS + 1) begin n_bad++; $display("FAIL %s_rise: got %0d want %0d", tag, (rise_q.size() > 0) ? rise_q[0] : -1, IFS + 1); end
    n_cmp++; if (last_bits !== e) begin n_bad++; $display("FAIL %s_bits: got %h want %h", tag, last_bits, e); end
    n_cmp++; if (done_t != IFS + 1 + LEN || done_cnt != 1 || fail_cnt != 0) begin n_bad++; $display("FAIL %s_done: got t=%0d n=%0d fail=%0d want t=%0d n=1 fail=0", tag, done_t, done_cnt, fail_cnt, IFS + 1 + LEN); end
    n_cmp++; if (retry_at_end !== 4'd0) begin n_bad++; $display("FAIL %s_retry: got %0d want 0", tag, retry_at_end); end
    $display("%s: frame %h.. sent, done at edge %0d", tag, f[FW-1 -: 32], done_t);
  endtask

  task automatic test_carrier_busy();
    logic [FW-1:0] f;
    int exp_rise;
    // Deterministic case: 40 busy cycles, then a blip seen when 10 idle cycles have been counted.
    clear_plan();
    for (int i = 1; i <= 40; i++) busy_plan[i] = 1'b1;
    busy_plan[40 + 11] = 1'b1;
    exp_rise = exp_first_rise();
    f = rand_frame();
    run_frame(f, -1, 0, -1, '0, 3000);
    n_cmp++; if (rise_q.size() < 1 || rise_q[0] != exp_rise) begin n_bad++; $display("FAIL busy_blip_rise: got %0d want %0d", (rise_q.size() > 0) ? rise_q[0] : -1, exp_rise); end
    n_cmp++; if (last_bits !== exp_stream(f) || done_cnt != 1) begin n_bad++; $display("FAIL busy_blip_bits: got done=%0d want 1 with matching bits", done_cnt); end
    $display("carrier_busy: blip case tx_en rose at %0d", (rise_q.size() > 0) ? rise_q[0] : -1);
    // Random carrier activity for the first 80 cycles.
    for (int r = 0; r < 3; r++) begin
      clear_plan();
      for (int i = 1; i <= 80; i++) busy_plan[i] = ($urandom_range(0, 3) == 0);
      exp_rise = exp_first_rise();
      f = rand_frame();
      run_frame(f, -1, 0, -1, '0, 3000);
      n_cmp++; if (rise_q.size() < 1 || rise_q[0] != exp_rise || last_bits !== exp_stream(f)) begin n_bad++; $display("FAIL busy_rand_rise: got %0d want %0d", (rise_q.size() > 0) ? rise_q[0] : -1, exp_rise); end
      $display("carrier_busy: random plan %0d tx_en rose at %0d", r, (rise_q.size() > 0) ? rise_q[0] : -1);
    end
    clear_plan();
  endtask

  task automatic test_collision();
    logic [FW-1:0] f;
    logic [LEN-1:0] e;
    int w;
    f = rand_frame();
    e = exp_stream(f);
    clear_plan();
    run_frame(f, 5, 1, -1, '0, 3000);
    n_cmp++; if (rise_q.size() != 2 || fall_q.size() != 2) begin n_bad++; $display("FAIL coll_attempts: got %0d rises want 2", rise_q.size()); end
    else begin
      n_cmp++; if (fall_q[0] != rise_q[0] + 6 || nbits_q[0] != 6) begin n_bad++; $display("FAIL coll_abort: got fall=%0d bits=%0d want fall=%0d bits=6", fall_q[0], nbits_q[0], rise_q[0] + 6); end
      n_cmp++; if (first_bits[5:0] !== e[LEN-1 -: 6]) begin n_bad++; $display("FAIL coll_partial: got %b want %b", first_bits[5:0], e[LEN-1 -: 6]); end
      w = rise_q[1] - fall_q[0] - (IFS + 2);
      n_cmp++; if (w != 0 && w != SLOT) begin n_bad++; $display("FAIL coll_backoff: got wait %0d want 0 or %0d", w, SLOT); end
      $display("collision: abort at bit 5, backoff %0d clks", w);
    end
    n_cmp++; if (last_bits !== e || done_cnt != 1 || fail_cnt != 0) begin n_bad++; $display("FAIL coll_resend: got done=%0d fail=%0d want 1/0 with full frame", done_cnt, fail_cnt); end
    n_cmp++; if (retry_at_end !== 4'd1) begin n_bad++; $display("FAIL coll_retry: got %0d want 1", retry_at_end); end
  endtask

  task automatic test_last_bit_collision();
    logic [FW-1:0] f;
    f = rand_frame();
    clear_plan();
    run_frame(f, LEN - 1, 1, -1, '0, 3000);
    n_cmp++; if (fall_q.size() != 2 || nbits_q[0] != LEN || done_t != fall_q[1]) begin n_bad++; $display("FAIL lastbit_abort: got falls=%0d done_t=%0d want 2 falls, done on second", fall_q.size(), done_t); end
    n_cmp++; if (retry_at_end !== 4'd1 || done_cnt != 1 || fail_cnt != 0 || last_bits !== exp_stream(f)) begin n_bad++; $display("FAIL lastbit_result: got retry=%0d done=%0d fail=%0d want 1/1/0", retry_at_end, done_cnt, fail_cnt); end
    $display("last_bit_collision: retry=%0d done at %0d", retry_at_end, done_t);
  endtask

  task automatic test_retry_limit();
    logic [FW-1:0] f;
    int pos, w, bound, kk;
    f = rand_frame();
    pos = $urandom_range(0, LEN - 1);
    clear_plan();
    run_frame(f, pos, 99, -1, '0, 25000);
    n_cmp++; if (timed_out != 0) begin n_bad++; $display("FAIL retry_timeout: got timeout want fail pulse"); end
    n_cmp++; if (rise_q.size() != MAXR || fall_q.size() != MAXR) begin n_bad++; $display("FAIL retry_attempts: got %0d want %0d", rise_q.size(), MAXR); end
    n_cmp++; if (fail_cnt != 1 || done_cnt != 0) begin n_bad++; $display("FAIL retry_pulses: got fail=%0d done=%0d want 1/0", fail_cnt, done_cnt); end
    n_cmp++; if (retry_at_end !== 4'(MAXR)) begin n_bad++; $display("FAIL retry_cnt: got %0d want %0d", retry_at_end, MAXR); end
    n_cmp++; if (fall_q.size() != MAXR || fail_t != fall_q[MAXR-1]) begin n_bad++; $display("FAIL retry_fail_t: got %0d want final abort edge", fail_t); end
    for (int n = 1; n < MAXR; n++) begin
      kk = (n < EXPMAX) ? n : EXPMAX;
      bound = ((1 << kk) - 1) * SLOT;
      w = (rise_q.size() > n && fall_q.size() >= n) ? rise_q[n] - fall_q[n-1] - (IFS + 2) : -1;
      n_cmp++; if (w < 0 || w > bound || (w % SLOT) != 0) begin n_bad++; $display("FAIL retry_backoff_%0d: got wait %0d want 0..%0d in slot steps", n, w, bound); end
      $display("retry_limit: collision %0d at bit %0d, backoff %0d (max %0d)", n, pos, w, bound);
    end
  endtask

  task automatic test_reset_mid_tx();
    logic [FW-1:0] f;
    f = rand_frame();
    bus.framed_message = f; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (IFS + 1 + 100) tick();
    n_cmp++; if (bus.tx_en !== 1'b1) begin n_bad++; $display("FAIL midreset_pre: got tx_en %b want 1", bus.tx_en); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({bus.tx_en, bus.tx_data, bus.busy} !== 3'b000) begin n_bad++; $display("FAIL midreset_async: got %b want 000", {bus.tx_en, bus.tx_data, bus.busy}); end
    repeat (2) tick();
    #2 reset = 1'b1;
    tick();
    $display("reset_mid_tx: reset applied at bit 100");
    test_idle_frame(rand_frame(), "after_reset");
  endtask

  task automatic test_start_while_busy();
    logic [FW-1:0] f, g;
    f = rand_frame();
    g = ~f;
    clear_plan();
    run_frame(f, -1, 0, 50, g, 2000);
    n_cmp++; if (last_bits !== exp_stream(f) || done_cnt != 1 || rise_q.size() != 1) begin n_bad++; $display("FAIL busy_start: got done=%0d rises=%0d want 1/1 with original frame", done_cnt, rise_q.size()); end
`ifdef CSMA_TX_PREAMBLE_EN
    n_cmp++; if (last_bits[LEN-1 -: 8] !== 8'b1101_0101) begin n_bad++; $display("FAIL preamble: got %b want 11010101", last_bits[LEN-1 -: 8]); end
`endif
    $display("start_while_busy: second start ignored, done at %0d", done_t);
  endtask

  initial begin
    test_reset();
    test_idle_inputs();
    test_idle_frame(256'h0123_4567_89AB_CDEF, "idle_frame");
    test_idle_frame(rand_frame(), "idle_rand");
    test_carrier_busy();
    test_collision();
    test_last_bit_collision();
    test_retry_limit();
    test_reset_mid_tx();
    test_start_while_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
